// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(XLEN) shift levels spread over STAGES register
// stages, with a single global stall driven by the output handshake.
module pipelined_shifter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_data,
  input  logic [$clog2(XLEN)-1:0]   in_shamt,
  input  logic [2:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_data,
  output logic [$clog2(STAGES):0]   occupancy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned PER = SHW / STAGES;
  localparam int unsigned OCW = $clog2(STAGES) + 1;
  // Only non-final stages carry control forward; the last stage needs just data/valid.
  localparam int unsigned CTL = (STAGES > 1) ? STAGES - 1 : 1;

  typedef enum logic [2:0] {
    M_SRL = 3'b000,
    M_SLL = 3'b001,
    M_SRA = 3'b010,
    M_ROR = 3'b011,
    M_ROL = 3'b100
  } mode_e;

  function automatic logic [XLEN-1:0] shift_level(
    input logic [XLEN-1:0] d,
    input logic [2:0]      m,
    input logic            sgn,
    input int unsigned     amt
  );
    logic [XLEN-1:0] ones;
    logic [XLEN-1:0] fill;
    logic [XLEN-1:0] r;
    ones = '1;
    fill = sgn ? ~(ones >> amt) : '0;
    case (m)
      M_SRL:   r = d >> amt;
      M_SLL:   r = d << amt;
      M_SRA:   r = (d >> amt) | fill;
      M_ROR:   r = (d >> amt) | (d << (XLEN - amt));
      M_ROL:   r = (d << amt) | (d >> (XLEN - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_levels(
    input logic [XLEN-1:0] d,
    input logic [2:0]      m,
    input logic            sgn,
    input logic [SHW-1:0]  sh,
    input int unsigned     lo,
    input int unsigned     hi
  );
    logic [XLEN-1:0] r;
    logic [SHW-1:0]  t;
    r = d;
    for (int unsigned lv = 0; lv < SHW; lv++) begin
      t = sh >> lv;
      if (lv >= lo && lv < hi && t[0]) begin
        r = shift_level(r, m, sgn, 32'd1 << lv);
      end
    end
    return r;
  endfunction

  logic [XLEN-1:0] data_q  [STAGES];
  logic            valid_q [STAGES];
  logic [2:0]      mode_q  [CTL];
  logic            sign_q  [CTL];
  logic [SHW-1:0]  shamt_q [CTL];
  logic [OCW-1:0]  occ_q;

  logic [XLEN-1:0] src_data  [STAGES];
  logic [2:0]      src_mode  [STAGES];
  logic            src_sign  [STAGES];
  logic [SHW-1:0]  src_shamt [STAGES];
  logic            valid_d   [STAGES];
  logic [XLEN-1:0] data_d    [STAGES];
  logic [OCW-1:0]  occ_d;
  logic            advance;

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign occupancy = occ_q;
  assign advance   = ~valid_q[STAGES-1] | out_ready;
  assign in_ready  = advance;

  always_comb begin
    src_data[0]  = in_data;
    src_mode[0]  = in_mode;
    src_sign[0]  = in_data[XLEN-1];
    src_shamt[0] = in_shamt;
    valid_d[0]   = in_valid;
    for (int unsigned s = 1; s < STAGES; s++) begin
      src_data[s]  = data_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_sign[s]  = sign_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      valid_d[s]   = valid_q[s-1];
    end
    occ_d = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      // Remainder levels fold into the final stage.
      data_d[s] = shift_levels(src_data[s], src_mode[s], src_sign[s], src_shamt[s],
                               s * PER, (s == STAGES - 1) ? SHW : (s + 1) * PER);
      occ_d = occ_d + OCW'(valid_d[s]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        data_q[s]  <= '0;
        valid_q[s] <= 1'b0;
      end
      for (int unsigned s = 0; s < CTL; s++) begin
        mode_q[s]  <= '0;
        sign_q[s]  <= 1'b0;
        shamt_q[s] <= '0;
      end
      occ_q <= '0;
    end else if (advance) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        data_q[s]  <= data_d[s];
        valid_q[s] <= valid_d[s];
      end
      for (int unsigned s = 0; s < CTL; s++) begin
        mode_q[s]  <= src_mode[s];
        sign_q[s]  <= src_sign[s];
        shamt_q[s] <= src_shamt[s];
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter (XLEN=32, STAGES=2).
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipelined_shifter #(.XLEN(32), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] sh, input logic [2:0] m);
    in_valid = v;
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
  endtask

  // One isolated op: result must appear exactly two cycles after presentation, once.
  task automatic single(input string tag, input logic [31:0] d, input logic [4:0] sh,
                        input logic [2:0] m, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, d, sh, m);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    chk({tag, "/valid_c1"}, 32'(out_valid), 32'd0);
    chk({tag, "/occ_c1"}, 32'(occupancy), 32'd1);
    @(negedge clk);
    chk({tag, "/valid_c2"}, 32'(out_valid), 32'd1);
    chk({tag, "/data"}, out_data, exp);
    @(negedge clk);
    chk({tag, "/valid_c3"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] d4 [8];
  logic [4:0]  s4 [8];
  logic [2:0]  m4 [8];
  logic [31:0] e4 [8];

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    #12;
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/occupancy", 32'(occupancy), 32'd0);
    chk("reset/out_data", out_data, 32'd0);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic shifts and rotates
    single("sra_80000000_4", 32'h8000_0000, 5'd4,  3'b010, 32'hF800_0000);
    single("srl_ffffffff_31", 32'hFFFF_FFFF, 5'd31, 3'b000, 32'h0000_0001);
    single("ror_1_1",        32'h0000_0001, 5'd1,  3'b011, 32'h8000_0000);
    single("rol_80000001_4", 32'h8000_0001, 5'd4,  3'b100, 32'h0000_0018);
    single("sll_f_28",       32'h0000_000F, 5'd28, 3'b001, 32'hF000_0000);

    // shamt 0 and pass-through
    single("srl_sh0", 32'hA5A5_A5A5, 5'd0, 3'b000, 32'hA5A5_A5A5);
    single("sll_sh0", 32'hA5A5_A5A5, 5'd0, 3'b001, 32'hA5A5_A5A5);
    single("sra_sh0", 32'hA5A5_A5A5, 5'd0, 3'b010, 32'hA5A5_A5A5);
    single("ror_sh0", 32'hA5A5_A5A5, 5'd0, 3'b011, 32'hA5A5_A5A5);
    single("rol_sh0", 32'hA5A5_A5A5, 5'd0, 3'b100, 32'hA5A5_A5A5);
    single("pass111_sh7", 32'hA5A5_A5A5, 5'd7, 3'b111, 32'hA5A5_A5A5);

    // Back-to-back stream of 8 ops
    d4[0] = 32'h0000_0001; s4[0] = 5'd5;  m4[0] = 3'b001; e4[0] = 32'h0000_0020;
    d4[1] = 32'h8000_0000; s4[1] = 5'd31; m4[1] = 3'b000; e4[1] = 32'h0000_0001;
    d4[2] = 32'h7FFF_FFFF; s4[2] = 5'd4;  m4[2] = 3'b010; e4[2] = 32'h07FF_FFFF;
    d4[3] = 32'h1234_5678; s4[3] = 5'd8;  m4[3] = 3'b011; e4[3] = 32'h7812_3456;
    d4[4] = 32'h1234_5678; s4[4] = 5'd8;  m4[4] = 3'b100; e4[4] = 32'h3456_7812;
    d4[5] = 32'hF000_0000; s4[5] = 5'd31; m4[5] = 3'b010; e4[5] = 32'hFFFF_FFFF;
    d4[6] = 32'hDEAD_BEEF; s4[6] = 5'd3;  m4[6] = 3'b101; e4[6] = 32'hDEAD_BEEF;
    d4[7] = 32'h8000_0000; s4[7] = 5'd1;  m4[7] = 3'b100; e4[7] = 32'h0000_0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk($sformatf("b2b/valid_%0d", c - 2), 32'(out_valid), 32'd1);
        chk($sformatf("b2b/data_%0d", c - 2), out_data, e4[c-2]);
      end
      if (c >= 2 && c <= 8) chk($sformatf("b2b/occ_c%0d", c), 32'(occupancy), 32'd2);
      if (c < 8) drive(1'b1, d4[c], s4[c], m4[c]);
      else       drive(1'b0, '0, '0, '0);
    end
    @(negedge clk);
    chk("b2b/drained_valid", 32'(out_valid), 32'd0);
    chk("b2b/drained_occ", 32'(occupancy), 32'd0);

    // Backpressure: A and B fill the pipe, C waits at the input
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0003, 5'd1, 3'b001);          // A -> 0x6
    @(negedge clk);
    chk("bp/in_ready_fill", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0000_0100, 5'd8, 3'b000);          // B -> 0x1
    @(negedge clk);
    drive(1'b1, 32'h0000_000F, 5'd4, 3'b011);          // C -> 0xF0000000
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp/in_ready_%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp/valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp/data_%0d", k), out_data, 32'h0000_0006);
      chk($sformatf("bp/occ_%0d", k), 32'(occupancy), 32'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp/release_a", out_data, 32'h0000_0006);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    chk("bp/valid_b", 32'(out_valid), 32'd1);
    chk("bp/data_b", out_data, 32'h0000_0001);
    @(negedge clk);
    chk("bp/valid_c", 32'(out_valid), 32'd1);
    chk("bp/data_c", out_data, 32'hF000_0000);
    @(negedge clk);
    chk("bp/no_dup", 32'(out_valid), 32'd0);
    chk("bp/occ_end", 32'(occupancy), 32'd0);

    // Reset with two ops in flight
    drive(1'b1, 32'h0000_0011, 5'd2, 3'b001);
    @(negedge clk);
    drive(1'b1, 32'h0000_0022, 5'd3, 3'b001);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    chk("rst/pre_valid", 32'(out_valid), 32'd1);
    chk("rst/pre_occ", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst/async_valid", 32'(out_valid), 32'd0);
    chk("rst/async_occ", 32'(occupancy), 32'd0);
    chk("rst/async_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst/no_stale_%0d", k), 32'(out_valid), 32'd0);
      chk($sformatf("rst/occ_%0d", k), 32'(occupancy), 32'd0);
    end
    single("post_rst_sll", 32'h0000_0001, 5'd31, 3'b001, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
